// File: rtl/counter_pkg.sv
// counter_pkg: shared encodings and parameter legality check for the counter datapath
package counter_pkg;
  localparam logic OP_UP = 1'b0;
  localparam logic OP_DOWN = 1'b1;
  localparam logic MODE_SAT = 1'b0;
  localparam logic MODE_WRAP = 1'b1;
  function automatic bit params_ok(int unsigned width, int unsigned max_val, int unsigned step);
    longint unsigned lim;
    lim = (64'd1 << width) - 64'd1;
    return width >= 2 && width <= 32 && max_val >= 1 &&
           longint'(max_val) <= longint'(lim) && step >= 1 && step <= max_val;
  endfunction
endpackage

// File: rtl/counter_next_calc.sv
// counter_next_calc: stepped next count and bound detection at WIDTH+1 bits
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MAX_VAL = 32'hFFFF_FFFF >> (32 - WIDTH),
  parameter int unsigned STEP = 1
) (
  input  logic [WIDTH-1:0] c,
  input  logic             op,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] next_c,
  output logic             bound_hit
);
  localparam logic [WIDTH:0] W_MAX = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] W_STEP = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0] W_MOD = W_MAX + (WIDTH + 1)'(1);
  logic [WIDTH:0] w_c;
  logic [WIDTH:0] w_up;
  logic [WIDTH:0] w_next;
  logic           w_up_hit;
  logic           w_dn_hit;
  assign w_c = {1'b0, c};
  assign w_up = w_c + W_STEP;
  assign w_up_hit = w_up > W_MAX;
  assign w_dn_hit = w_c < W_STEP;
  // a bounded step either wraps modulo MAX_VAL+1 or pins at the bound it crossed
  always_comb begin
    w_next = (op == OP_DOWN)
      ? (w_dn_hit ? ((wrap_en == MODE_WRAP) ? w_c + W_MOD - W_STEP : '0) : w_c - W_STEP)
      : (w_up_hit ? ((wrap_en == MODE_WRAP) ? w_up - W_MOD : W_MAX) : w_up);
    bound_hit = (op == OP_DOWN) ? w_dn_hit : w_up_hit;
  end
  assign next_c = w_next[WIDTH-1:0];
endmodule

// File: rtl/counter_datapath_param.sv
// counter_datapath_param: parametrised up/down counter register with clear, load and terminal-count pulse
module counter_datapath_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MAX_VAL = 32'hFFFF_FFFF >> (32 - WIDTH),
  parameter int unsigned STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op,
  input  logic             c_ld,
  input  logic             c_clr,
  input  logic             d_ld,
  input  logic [WIDTH-1:0] d_in,
  input  logic             wrap_en,
  output logic             z,
  output logic             m,
  output logic             tc,
  output logic [WIDTH-1:0] c_out
);
  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);
  if (!params_ok(WIDTH, MAX_VAL, STEP)) begin : g_bad_params
    $error("counter_datapath_param: illegal WIDTH/MAX_VAL/STEP");
  end
  logic [WIDTH-1:0] r_c;
  logic             r_tc;
  logic [WIDTH-1:0] w_next;
  logic             w_hit;
  logic [WIDTH-1:0] w_load;
  counter_next_calc #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .STEP(STEP)) u_next (
    .c(r_c),
    .op(op),
    .wrap_en(wrap_en),
    .next_c(w_next),
    .bound_hit(w_hit)
  );
  assign w_load = (d_in > C_MAX) ? C_MAX : d_in;
  // count register and tc flop: clear beats load beats step beats hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c <= '0;
      r_tc <= 1'b0;
    end else begin
      r_c <= c_clr ? '0 : d_ld ? w_load : c_ld ? w_next : r_c;
      r_tc <= !c_clr && !d_ld && c_ld && w_hit;
    end
  end
  assign c_out = r_c;
  assign tc = r_tc;
  assign z = r_c == '0;
  assign m = r_c == C_MAX;
endmodule

// File: tb/tb_counter_datapath_param.sv
// tb_counter_datapath_param: directed checks of the counter datapath in a small and a default configuration
module tb_counter_datapath_param;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a_op = 1'b0, a_c_ld = 1'b0, a_c_clr = 1'b0, a_d_ld = 1'b0, a_wrap = 1'b0;
  logic [3:0] a_d_in = '0;
  logic a_z, a_m, a_tc;
  logic [3:0] a_c;
  logic b_op = 1'b0, b_c_ld = 1'b0, b_c_clr = 1'b0, b_d_ld = 1'b0, b_wrap = 1'b0;
  logic [15:0] b_d_in = '0;
  logic b_z, b_m, b_tc;
  logic [15:0] b_c;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  counter_datapath_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3)) u_a (
    .clk(clk), .reset(reset), .op(a_op), .c_ld(a_c_ld), .c_clr(a_c_clr), .d_ld(a_d_ld),
    .d_in(a_d_in), .wrap_en(a_wrap), .z(a_z), .m(a_m), .tc(a_tc), .c_out(a_c)
  );
  counter_datapath_param u_b (
    .clk(clk), .reset(reset), .op(b_op), .c_ld(b_c_ld), .c_clr(b_c_clr), .d_ld(b_d_ld),
    .d_in(b_d_in), .wrap_en(b_wrap), .z(b_z), .m(b_m), .tc(b_tc), .c_out(b_c)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic a_ctl(input logic clr, input logic ld, input logic cl, input logic op, input logic wr, input logic [3:0] d);
    a_c_clr = clr; a_d_ld = ld; a_c_ld = cl; a_op = op; a_wrap = wr; a_d_in = d;
  endtask
  initial begin
    logic [3:0] up_wrap_c[4] = '{4'd3, 4'd6, 4'd9, 4'd2};
    logic       up_wrap_t[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] up_sat_c[5] = '{4'd3, 4'd6, 4'd9, 4'd9, 4'd9};
    logic       up_sat_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tick; tick;
    reset = 1'b0;
    tick;
    chk("rst_c", 32'(a_c), 0);
    chk("rst_z", 32'(a_z), 1);
    chk("rst_m", 32'(a_m), 0);
    chk("rst_tc", 32'(a_tc), 0);
    a_ctl(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("wrap_up_c%0d", i), 32'(a_c), 32'(up_wrap_c[i]));
      chk($sformatf("wrap_up_tc%0d", i), 32'(a_tc), 32'(up_wrap_t[i]));
      chk($sformatf("wrap_up_m%0d", i), 32'(a_m), 32'(up_wrap_c[i] == 4'd9));
    end
    a_ctl(1, 0, 0, 0, 1, 0);
    tick;
    chk("clr_c", 32'(a_c), 0);
    chk("clr_tc", 32'(a_tc), 0);
    a_ctl(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("sat_up_c%0d", i), 32'(a_c), 32'(up_sat_c[i]));
      chk($sformatf("sat_up_tc%0d", i), 32'(a_tc), 32'(up_sat_t[i]));
    end
    a_ctl(0, 1, 0, 0, 1, 2);
    tick;
    chk("ld2_c", 32'(a_c), 2);
    chk("ld2_tc", 32'(a_tc), 0);
    a_ctl(0, 0, 1, 1, 1, 0);
    tick;
    chk("wrap_dn_c", 32'(a_c), 9);
    chk("wrap_dn_tc", 32'(a_tc), 1);
    a_ctl(0, 1, 0, 1, 0, 2);
    tick;
    a_ctl(0, 0, 1, 1, 0, 0);
    tick;
    chk("sat_dn_c", 32'(a_c), 0);
    chk("sat_dn_tc", 32'(a_tc), 1);
    chk("sat_dn_z", 32'(a_z), 1);
    a_ctl(0, 0, 0, 0, 0, 0);
    tick;
    chk("hold_c", 32'(a_c), 0);
    chk("hold_tc", 32'(a_tc), 0);
    a_ctl(0, 1, 0, 0, 0, 7);
    tick;
    a_ctl(0, 0, 1, 1, 0, 0);
    tick;
    chk("dn_step_c", 32'(a_c), 4);
    chk("dn_step_tc", 32'(a_tc), 0);
    a_ctl(1, 1, 1, 0, 1, 5);
    tick;
    chk("prio_clr_c", 32'(a_c), 0);
    a_ctl(0, 1, 1, 0, 1, 4);
    tick;
    chk("prio_ld_c", 32'(a_c), 4);
    chk("prio_ld_tc", 32'(a_tc), 0);
    a_ctl(0, 1, 0, 0, 1, 15);
    tick;
    chk("clamp_c", 32'(a_c), 9);
    chk("clamp_m", 32'(a_m), 1);
    chk("clamp_tc", 32'(a_tc), 0);
    a_ctl(0, 0, 1, 0, 1, 0);
    tick;
    chk("pre_tc", 32'(a_tc), 1);
    a_ctl(0, 1, 0, 0, 1, 6);
    tick;
    chk("pre_rst_c", 32'(a_c), 6);
    a_ctl(0, 0, 1, 0, 1, 0);
    reset = 1'b1;
    #1;
    chk("async_rst_c", 32'(a_c), 0);
    chk("async_rst_z", 32'(a_z), 1);
    tick;
    reset = 1'b0;
    a_ctl(0, 0, 0, 0, 1, 0);
    b_d_in = 16'hFFFF; b_d_ld = 1'b1; b_wrap = 1'b1;
    tick;
    chk("b_ld_m", 32'(b_m), 1);
    b_d_ld = 1'b0; b_c_ld = 1'b1; b_op = 1'b0;
    tick;
    chk("b_up_c", 32'(b_c), 0);
    chk("b_up_tc", 32'(b_tc), 1);
    chk("b_up_z", 32'(b_z), 1);
    b_op = 1'b1;
    tick;
    chk("b_dn_c", 32'(b_c), 65535);
    chk("b_dn_m", 32'(b_m), 1);
    chk("b_dn_tc", 32'(b_tc), 1);
    b_op = 1'b1;
    tick;
    chk("b_dn2_c", 32'(b_c), 65534);
    chk("b_dn2_tc", 32'(b_tc), 0);
    b_c_ld = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_datapath_param.md
Name: counter_datapath_param

Overview:
Parametrised up/down counter datapath for the controller/datapath designs in this codebase. Generalises the fixed 16-bit ±1 counter in four ways: configurable width, modulus and step; run-time wrap/saturate mode; parallel load; and a registered terminal-count event. An external FSM drives it through control signals and reads status flags back. The datapath contains no FSM of its own.

Parameters:
WIDTH, 16, counter width in bits (2..32)
MAX_VAL, 2**WIDTH-1, upper bound of the count range [0, MAX_VAL]; must be ≤ 2**WIDTH-1 and ≥ 1
STEP, 1, increment/decrement magnitude; must satisfy 1 ≤ STEP ≤ MAX_VAL

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op  in  1  direction: 0 = up (add STEP), 1 = down (subtract STEP)
c_ld  in  1  count enable: register takes the next stepped value this cycle
c_clr  in  1  synchronous clear to 0
d_ld  in  1  synchronous parallel load of d_in
d_in  in  WIDTH  parallel load value
wrap_en  in  1  1 = modulo (wrap) mode, 0 = saturate mode; sampled every cycle
z  out  1  combinational: c_out == 0
m  out  1  combinational: c_out == MAX_VAL
tc  out  1  registered one-cycle pulse: the previous step hit a bound
c_out  out  WIDTH  current count register

Behaviour:
- Reset (async, active-high): c_out = 0, tc = 0. z = 1 and m = 0 follow from the count. Reset mid-operation aborts the step in progress; no partial update.
- Priority per rising edge: c_clr > d_ld > c_ld > hold.
- c_clr: c_out <= 0, tc <= 0.
- d_ld: c_out <= min(d_in, MAX_VAL), so out-of-range loads clamp. tc <= 0.
- c_ld with op = 0 (up):
  - If c + STEP ≤ MAX_VAL: c <= c + STEP, tc <= 0.
  - Otherwise, wrap mode: c <= c + STEP − (MAX_VAL+1). Saturate mode: c <= MAX_VAL. In both cases tc <= 1.
- c_ld with op = 1 (down):
  - If c ≥ STEP: c <= c − STEP, tc <= 0.
  - Otherwise, wrap mode: c <= c + (MAX_VAL+1) − STEP. Saturate mode: c <= 0. In both cases tc <= 1.
- Saturate mode held at a bound with c_ld asserted: c stays put and tc pulses every cycle, once per attempted step.
- Hold (no control asserted): c unchanged, tc <= 0.
- Arithmetic: compute internally at WIDTH+1 bits so c + STEP never overflows before the compare. The result is always in [0, MAX_VAL].
- Latency: c_out and tc update 1 cycle after the control sample. z and m are combinational from c_out, so no added latency.
- wrap_en changing mid-count has effect from the next c_ld; the current count is never altered.
- The datapath has no combinational path from inputs to outputs except through c_out.

Decomposition:
- Shared package counter_pkg holds:
  - OP_UP = 1'b0, OP_DOWN = 1'b1
  - MODE_SAT = 1'b0, MODE_WRAP = 1'b1
  - a parameter-legality check function used by an initial assertion
- One combinational sub-module, counter_next_calc (parameters WIDTH, MAX_VAL, STEP):
  - inputs: c, op, wrap_en
  - outputs: next_c, bound_hit
  - The top-level holds the register, priority mux, tc flop and comparators.

Test Plan:
- Reset release, WIDTH=4, MAX_VAL=9, STEP=3 → c_out=0, z=1, m=0, tc=0. Asserting reset mid-count (c=6) → c_out=0 asynchronously, before the next edge.
- Wrap up: wrap_en=1, op=0, c_ld held 4 cycles from 0 → c_out 3, 6, 9, 2. m=1 at 9. tc=1 only in the cycle c_out becomes 2.
- Saturate up: wrap_en=0, op=0, c_ld held 5 cycles from 0 → 3, 6, 9, 9, 9. tc=0, 0, 0, 1, 1.
- Wrap/saturate down: from c=2 with op=1, c_ld → wrap_en=1 gives 9 with tc=1; wrap_en=0 gives 0 with tc=1 and z=1.
- Priority and load: c_clr=d_ld=c_ld=1 with d_in=5 → c_out=0. Then d_ld=1, d_in=15 → c_out=9 (clamped), m=1, tc=0.
- Defaults (WIDTH=16, MAX_VAL=65535, STEP=1), wrap mode: up from 65535 → 0 with tc=1, z=1. Down from 0 → 65535 with m=1.
